store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries; it is a power of 2 in the range 2..16.
REQ-002 Port clk  in  1  clock, rising-edge active.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port st_valid  in  1  store request from the pipeline.
REQ-005 Port st_ready  out  1  buffer can accept a store this cycle.
REQ-006 Port st_type  in  2  store type: 00 sw, 01 sh, 10 sb, 11 reserved.
REQ-007 Port st_addr  in  32  byte address of the store.
REQ-008 Port st_data  in  32  store data, right-justified for sh and sb.
REQ-009 Port mem_req  out  1  write request to data memory.
REQ-010 Port mem_ack  in  1  memory accepts the presented write at this edge.
REQ-011 Port mem_addr  out  10  word address, equal to entry address bits [11:2].
REQ-012 Port mem_be  out  4  byte enables; bit i selects byte lane [8i+7:8i].
REQ-013 Port mem_wdata  out  32  lane-aligned write data.
REQ-014 Port ld_valid  in  1  a load is in the memory stage.
REQ-015 Port ld_addr  in  32  byte address of the load.
REQ-016 Port ld_hazard  out  1  the load word matches a pending store.
REQ-017 Port misalign_err  out  1  one-cycle pulse when a store is rejected.
REQ-018 Port count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries, each holding {addr[11:2], be, wdata}; the write and read pointers SHALL wrap modulo DEPTH.
REQ-020 st_ready SHALL equal (count < DEPTH), driven from registered state only and independent of st_valid and mem_ack.
REQ-021 A store SHALL be accepted at a rising edge when st_valid=1 and st_ready=1; a store is not accepted when the buffer is full, even if a pop occurs in the same cycle.
REQ-022 Lane encoding for sw: be=1111, wdata=st_data.
REQ-023 Lane encoding for sh: be=0011 if addr[1]=0, else be=1100; wdata={st_data[15:0],st_data[15:0]}.
REQ-024 Lane encoding for sb: be=0001<<addr[1:0]; wdata={4{st_data[7:0]}}.
REQ-025 A handshake with sw and addr[1:0]!=0, sh and addr[0]=1, or st_type=11 SHALL NOT be enqueued; misalign_err SHALL be 1 for exactly the following cycle, and count SHALL be unchanged.
REQ-026 The drain FSM SHALL have two states, IDLE and REQ; mem_req SHALL equal (state==REQ).
REQ-027 IDLE to REQ SHALL occur at the edge where registered count is nonzero, giving 2-cycle minimum latency from store accept to mem_req=1.
REQ-028 In REQ, mem_addr, mem_be and mem_wdata SHALL present the head entry and hold stable until mem_ack=1.
REQ-029 In REQ with mem_ack=1, the head SHALL be popped; the FSM SHALL stay in REQ if entries remain after the pop, counting any simultaneous push, and otherwise go to IDLE.
REQ-030 mem_ack SHALL be ignored in IDLE.
REQ-031 When mem_req=0, mem_addr, mem_be and mem_wdata SHALL be 0.
REQ-032 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; stores SHALL issue in acceptance order.
REQ-033 ld_hazard SHALL be combinational: ld_valid=1 and some occupied entry, including the head being presented, has addr equal to ld_addr[11:2]; byte enables are not compared.
REQ-034 An entry SHALL stop contributing to ld_hazard in the cycle after it is popped.

Reset
REQ-035 Asynchronous reset SHALL immediately force state=IDLE, both pointers=0, count=0, mem_req=0, misalign_err=0, and mem_addr/mem_be/mem_wdata=0.
REQ-036 Reset during REQ SHALL discard all pending stores; none is issued after reset deasserts.
REQ-037 Entry contents need not be cleared.

Verification
REQ-038 sb, addr 0x13, data 0xAB -> mem_req=1 two cycles later with mem_addr=0x004, mem_be=1000, mem_wdata=0xABABABAB; after mem_ack, count=0 and the FSM returns to IDLE.
REQ-039 sh, addr 0x2, data 0x1234 -> mem_be=1100, mem_wdata=0x12341234, mem_addr=0x000.
REQ-040 mem_ack=0 with four sw to 0x0, 0x4, 0x8, 0xC -> count=4 and st_ready=0, and a fifth store is held; one mem_ack -> st_ready=1 the next cycle; writes issue in order 0,1,2,3.
REQ-041 sw to 0x6 -> not enqueued, misalign_err=1 for one cycle, count unchanged; st_type=11 gives the same result.
REQ-042 Pending sw to 0x100 with ld_valid=1, ld_addr=0x102 -> ld_hazard=1; after that entry's mem_ack, ld_hazard=0 the next cycle.
REQ-043 Three stores queued with reset pulsed while mem_req=1 -> mem_req=0 and count=0 without waiting for a clock edge; no mem_req after release until a new store is accepted.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Circular store buffer between the pipeline and data memory.
//            It accepts aligned sw/sh/sb stores, converts each one to a
//            lane-aligned word write with byte enables, and drains the
//            entries to memory in order through a two-state req/ack FSM.
//            Misaligned or reserved-type stores are dropped and flagged.
//            It also flags a load whose word address matches a pending store.
// Ports    : clk, reset            - clock (rising edge), async active-high reset
//            st_valid/st_ready     - store handshake
//            st_type/addr/data     - store type (00 sw, 01 sh, 10 sb), address, data
//            mem_req/mem_ack       - memory write handshake
//            mem_addr/be/wdata     - head entry (all zero while mem_req=0)
//            ld_valid/ld_addr      - load in the memory stage
//            ld_hazard             - load word matches an occupied entry
//            misalign_err          - one-cycle pulse for a rejected store
//            count                 - number of occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [1:0]                 st_type,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [9:0]                 mem_addr,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hazard,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Entry storage; contents are never cleared, occupancy is tracked by the
  // pointers and count alone.
  logic [9:0]  r_ent_addr  [DEPTH];
  logic [3:0]  r_ent_be    [DEPTH];
  logic [31:0] r_ent_wdata [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [0:0]    r_state;
  logic          r_misalign_err;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_bad;
  logic          w_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_req;
  logic [CW-1:0] w_count_nxt;
  logic [DEPTH-1:0] w_hit;
  logic          w_unused;

  // Address bits that play no part in word addressing.
  assign w_unused = ^{st_addr[31:12], ld_addr[31:12], ld_addr[1:0]};

  // Lane encoding of the incoming store and alignment check.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    w_bad   = 1'b0;
    case (st_type)
      2'b00: begin
        w_be    = 4'b1111;
        w_wdata = st_data;
        w_bad   = (st_addr[1:0] != 2'b00);
      end
      2'b01: begin
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data[15:0]}};
        w_bad   = st_addr[0];
      end
      2'b10: begin
        w_be    = 4'b0001 << st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      default: begin
        w_bad   = 1'b1;
      end
    endcase
  end

  // Readiness depends only on registered occupancy, so a pop in the same
  // cycle never frees a slot for a store arriving against a full buffer.
  assign st_ready    = (r_count < C_DEPTH);
  assign w_hs        = st_valid && st_ready;
  assign w_push      = w_hs && !w_bad;
  assign w_req       = (r_state == S_REQ);
  assign w_pop       = w_req && mem_ack;
  assign w_count_nxt = r_count + (w_push ? C_CNT_ONE : '0) - (w_pop ? C_CNT_ONE : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_state        <= S_IDLE;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_hs && w_bad;
      r_count        <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state <= S_REQ;
          end
        end
        default: begin
          // Stay in REQ while anything remains, including a store pushed
          // in the same cycle as the pop.
          if (w_pop && (w_count_nxt == '0)) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_addr[r_wr_ptr]  <= st_addr[11:2];
      r_ent_be[r_wr_ptr]    <= w_be;
      r_ent_wdata[r_wr_ptr] <= w_wdata;
    end
  end

  assign mem_req      = w_req;
  assign mem_addr     = w_req ? r_ent_addr[r_rd_ptr]  : 10'h0;
  assign mem_be       = w_req ? r_ent_be[r_rd_ptr]    : 4'h0;
  assign mem_wdata    = w_req ? r_ent_wdata[r_rd_ptr] : 32'h0;
  assign misalign_err = r_misalign_err;
  assign count        = r_count;

  // An entry is occupied when its distance from the head is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
      logic [AW-1:0] w_off;
      assign w_off     = AW'(gi) - r_rd_ptr;
      assign w_hit[gi] = ({1'b0, w_off} < r_count) &&
                         (r_ent_addr[gi] == ld_addr[11:2]);
    end
  endgenerate

  assign ld_hazard = ld_valid && (|w_hit);

endmodule
`default_nettype wire
